uart_cmd_ctrl: RTL and testbench

Command sequencer between the 7-bit host input bus and the UART transmit engine/prescaler. It decodes 2-bit commands with a 5-bit payload, assembles TX bytes from nibble pairs, and hands them to the TX engine with a one-entry holding buffer. It stages the prescaler divisor and commits it only between frames, and drives an 8-bit status/readback mux.

---
 rtl/uart_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer between a 7-bit host command bus and a UART
// TX engine / prescaler.
//   clk, reset            : clock, synchronous active-high reset
//   io_in7, cmd_stb       : {payload[4:0], cmd[1:0]}, accepted on cmd_stb 0->1
//   tx_data/valid/ready   : byte offer to the TX engine (one-entry hold behind it)
//   tx_busy               : TX engine mid-frame; blocks divisor commit
//   prediv, cfg           : committed divisor, {stop2, parity_odd, parity_en}
//   io_resetCommandStrobe : one-cycle pulse on the CONFIG-reset command
//   io_out8               : registered status/readback mux
// Optional: define UART_CMD_TIMEOUT_EN to drop a stale low nibble after a timeout.
module uart_cmd_ctrl #(
    parameter int unsigned PREDIV_W  = 8,
    parameter logic [7:0]  RESET_DIV = 8'd1,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          io_in7,
    input  logic                cmd_stb,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic                tx_busy,
    output logic [PREDIV_W-1:0] prediv,
    output logic [2:0]          cfg,
    output logic                io_resetCommandStrobe,
    output logic [7:0]          io_out8
);

    if (PREDIV_W != 8) begin : g_bad_prediv_w
        $error("uart_cmd_ctrl: PREDIV_W must be 8");
    end
    if (TIMEOUT_W < 1) begin : g_bad_timeout_w
        $error("uart_cmd_ctrl: TIMEOUT_W must be at least 1");
    end

    typedef enum logic [1:0] {CMD_DATA, CMD_CONFIG, CMD_PREDIV, CMD_SPARE} cmd_e;
    typedef enum logic {TX_IDLE, TX_OFFER} tx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic          stb_q, stb_d;
    logic [3:0]    data_lo_q, data_lo_d;
    logic          lo_held_q, lo_held_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          overrun_q, overrun_d;
    logic          illegal_q, illegal_d;
    logic [2:0]    cfg_q, cfg_d;
    logic [1:0]    out_sel_q, out_sel_d;
    logic [7:0]    shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [7:0]    prediv_q, prediv_d;
    logic          rst_strobe_q, rst_strobe_d;
    logic [7:0]    cmd_cnt_q, cmd_cnt_d;
    logic [7:0]    io_out8_q, io_out8_d;
`ifdef UART_CMD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_q, to_d;
`endif

    logic       accept;
    logic       tx_accept;
    logic       cfg_rst;
    cmd_e       cmd;
    logic [4:0] p;
    logic [7:0] new_byte;

    assign accept    = cmd_stb && !stb_q;
    assign cmd       = cmd_e'(io_in7[1:0]);
    assign p         = io_in7[6:2];
    assign new_byte  = {p[3:0], data_lo_q};
    assign tx_accept = (tx_state_q == TX_OFFER) && tx_ready;

    always_comb begin
        stb_d        = cmd_stb;
        tx_state_d   = tx_state_q;
        data_lo_d    = data_lo_q;
        lo_held_d    = lo_held_q;
        tx_data_d    = tx_data_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        overrun_d    = overrun_q;
        illegal_d    = illegal_q;
        cfg_d        = cfg_q;
        out_sel_d    = out_sel_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        prediv_d     = prediv_q;
        rst_strobe_d = 1'b0;
        cmd_cnt_d    = cmd_cnt_q;
        cfg_rst      = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
        to_d         = to_q;
        // A DATA command in the same cycle wins over expiry.
        if (lo_held_q && !(accept && cmd == CMD_DATA)) begin
            if (to_q == '0) begin
                lo_held_d = 1'b0;
                illegal_d = 1'b1;
            end else begin
                to_d = to_q - 1'b1;
            end
        end
`endif

        // Divisor commit only between frames; a zero divisor is forced to 1.
        if (pending_q && !tx_busy && (tx_state_q == TX_IDLE)) begin
            prediv_d  = (shadow_q == '0) ? 8'd1 : shadow_q;
            pending_d = 1'b0;
        end

        // Drain first so an enqueue in the same cycle sees the freed slot.
        if (tx_accept) begin
            if (hold_full_q) begin
                tx_data_d   = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_state_d  = TX_IDLE;
            end
        end

        if (accept) begin
            cmd_cnt_d = cmd_cnt_q + 8'd1;
            unique case (cmd)
                CMD_DATA: begin
                    if (!p[4]) begin
                        data_lo_d = p[3:0];
                        lo_held_d = 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
                        to_d      = '1;
`endif
                    end else if (lo_held_q) begin
                        lo_held_d = 1'b0;
                        if (tx_state_d == TX_IDLE) begin
                            tx_data_d  = new_byte;
                            tx_state_d = TX_OFFER;
                        end else if (!hold_full_d) begin
                            hold_d      = new_byte;
                            hold_full_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                CMD_CONFIG: begin
                    unique case (p[4:3])
                        2'b00: cfg_d     = p[2:0];
                        2'b01: out_sel_d = p[1:0];
                        2'b10: begin
                            overrun_d = 1'b0;
                            illegal_d = 1'b0;
                        end
                        default: begin
                            if (p == 5'b11000) cfg_rst   = 1'b1;
                            else               illegal_d = 1'b1;
                        end
                    endcase
                end
                CMD_PREDIV: begin
                    if (!p[4]) begin
                        shadow_d[3:0] = p[3:0];
                    end else begin
                        shadow_d[7:4] = p[3:0];
                        pending_d     = 1'b1;
                    end
                end
                CMD_SPARE: illegal_d = 1'b1;
            endcase
        end

        // CONFIG-reset overrides every other update made above.
        if (cfg_rst) begin
            rst_strobe_d = 1'b1;
            cfg_d        = '0;
            overrun_d    = 1'b0;
            illegal_d    = 1'b0;
            shadow_d     = '0;
            pending_d    = 1'b0;
            prediv_d     = RESET_DIV;
            tx_state_d   = TX_IDLE;
            tx_data_d    = '0;
            hold_full_d  = 1'b0;
            lo_held_d    = 1'b0;
        end

        unique case (out_sel_q)
            2'd0: io_out8_d = {overrun_q, illegal_q, hold_full_q, tx_busy, pending_q, cfg_q};
            2'd1: io_out8_d = prediv_q;
            2'd2: io_out8_d = tx_data_q;
            default: io_out8_d = cmd_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q   <= TX_IDLE;
            stb_q        <= 1'b0;
            data_lo_q    <= '0;
            lo_held_q    <= 1'b0;
            tx_data_q    <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            overrun_q    <= 1'b0;
            illegal_q    <= 1'b0;
            cfg_q        <= '0;
            out_sel_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            prediv_q     <= RESET_DIV;
            rst_strobe_q <= 1'b0;
            cmd_cnt_q    <= '0;
            io_out8_q    <= '0;
`ifdef UART_CMD_TIMEOUT_EN
            to_q         <= '0;
`endif
        end else begin
            tx_state_q   <= tx_state_d;
            stb_q        <= stb_d;
            data_lo_q    <= data_lo_d;
            lo_held_q    <= lo_held_d;
            tx_data_q    <= tx_data_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            overrun_q    <= overrun_d;
            illegal_q    <= illegal_d;
            cfg_q        <= cfg_d;
            out_sel_q    <= out_sel_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            prediv_q     <= prediv_d;
            rst_strobe_q <= rst_strobe_d;
            cmd_cnt_q    <= cmd_cnt_d;
            io_out8_q    <= io_out8_d;
`ifdef UART_CMD_TIMEOUT_EN
            to_q         <= to_d;
`endif
        end
    end

    assign tx_data               = tx_data_q;
    assign tx_valid              = (tx_state_q == TX_OFFER);
    assign prediv                = prediv_q;
    assign cfg                   = cfg_q;
    assign io_resetCommandStrobe = rst_strobe_q;
    assign io_out8               = io_out8_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed testbench for uart_cmd_ctrl: command decode, byte assembly,
// offer/hold/overrun, staged divisor commit, CONFIG-reset and readback.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] io_in7;
    logic       cmd_stb;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic [7:0] prediv;
    logic [2:0] cfg;
    logic       io_resetCommandStrobe;
    logic [7:0] io_out8;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    uart_cmd_ctrl #(.PREDIV_W(8), .RESET_DIV(8'd1), .TIMEOUT_W(8)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .io_in7                (io_in7),
        .cmd_stb               (cmd_stb),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .tx_busy               (tx_busy),
        .prediv                (prediv),
        .cfg                   (cfg),
        .io_resetCommandStrobe (io_resetCommandStrobe),
        .io_out8               (io_out8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Rising strobe edge; returns just after the accepting clock edge.
    task automatic cmd_pulse(input logic [1:0] c, input logic [4:0] pl);
        io_in7  = {pl, c};
        cmd_stb = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        tick();
        cmd_stb = 1'b0;
    endtask

    // Full command: accepting edge plus one idle edge to re-arm edge detection.
    task automatic send_cmd(input logic [1:0] c, input logic [4:0] pl);
        cmd_pulse(c, pl);
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        io_in7   = '0;
        cmd_stb  = 1'b0;
        tx_ready = 1'b0;
        tx_busy  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_prediv",  prediv, 8'h01);
        check("rst_cfg",     {5'b0, cfg}, 8'h00);
        check("rst_valid",   {7'b0, tx_valid}, 8'h00);
        check("rst_txdata",  tx_data, 8'h00);
        check("rst_strobe",  {7'b0, io_resetCommandStrobe}, 8'h00);
        tick();
        check("rst_out8",    io_out8, 8'h00);

        // Byte assembly with ready sink
        tx_ready = 1'b1;
        send_cmd(2'd0, 5'h05);
        cmd_pulse(2'd0, 5'h1A);
        check("a5_valid",    {7'b0, tx_valid}, 8'h01);
        check("a5_data",     tx_data, 8'hA5);
        tick();
        check("a5_drop",     {7'b0, tx_valid}, 8'h00);
        send_cmd(2'd1, 5'h0B);            // out_sel = 3
        check("cnt_3",       io_out8, exp_cnt);
        send_cmd(2'd1, 5'h08);            // out_sel = 0

        // Offer / hold / overrun with stalled sink
        tx_ready = 1'b0;
        send_cmd(2'd0, 5'h01); send_cmd(2'd0, 5'h11);
        send_cmd(2'd0, 5'h02); send_cmd(2'd0, 5'h12);
        send_cmd(2'd0, 5'h03); send_cmd(2'd0, 5'h13);
        check("ovr_valid",   {7'b0, tx_valid}, 8'h01);
        check("ovr_data",    tx_data, 8'h11);
        check("ovr_status",  io_out8, 8'hA0);
        tx_ready = 1'b1;
        tick();
        check("hold_valid",  {7'b0, tx_valid}, 8'h01);
        check("hold_data",   tx_data, 8'h22);
        tick();
        check("drain_valid", {7'b0, tx_valid}, 8'h00);
        tick();
        check("no33_valid",  {7'b0, tx_valid}, 8'h00);
        check("no33_data",   tx_data, 8'h22);
        send_cmd(2'd1, 5'h10);
        check("flag_clr",    io_out8, 8'h00);

        // Staged divisor held off while busy
        tx_busy = 1'b1;
        send_cmd(2'd2, 5'h03);
        send_cmd(2'd2, 5'h12);
        check("busy_prediv", prediv, 8'h01);
        check("busy_status", io_out8, 8'h18);
        tx_busy = 1'b0;
        tick();
        check("commit",      prediv, 8'h23);
        tick();
        check("commit_pend", io_out8, 8'h00);
        send_cmd(2'd2, 5'h00);
        send_cmd(2'd2, 5'h10);
        check("zero_div",    prediv, 8'h01);

        // CONFIG-reset in the middle of an offer with a held byte
        send_cmd(2'd1, 5'h05);
        check("cfg_5",       {5'b0, cfg}, 8'h05);
        send_cmd(2'd2, 5'h07);
        send_cmd(2'd2, 5'h10);
        check("div_7",       prediv, 8'h07);
        tx_ready = 1'b0;
        send_cmd(2'd0, 5'h04); send_cmd(2'd0, 5'h14);
        send_cmd(2'd0, 5'h05); send_cmd(2'd0, 5'h15);
        check("pre_data",    tx_data, 8'h44);
        send_cmd(2'd0, 5'h09);            // low nibble left pending
        send_cmd(2'd3, 5'h00);            // SPARE -> illegal
        check("pre_status",  io_out8, 8'h65);
        cmd_pulse(2'd1, 5'h18);
        check("cr_strobe",   {7'b0, io_resetCommandStrobe}, 8'h01);
        check("cr_valid",    {7'b0, tx_valid}, 8'h00);
        check("cr_prediv",   prediv, 8'h01);
        check("cr_cfg",      {5'b0, cfg}, 8'h00);
        tick();
        check("cr_strobe1",  {7'b0, io_resetCommandStrobe}, 8'h00);
        check("cr_status",   io_out8, 8'h00);
        tx_ready = 1'b1;
        tick();
        check("cr_flushed",  {7'b0, tx_valid}, 8'h00);
        send_cmd(2'd0, 5'h16);            // high nibble with no low nibble held
        check("cr_lo_clr",   io_out8, 8'h40);
        check("cr_no_byte",  {7'b0, tx_valid}, 8'h00);
        send_cmd(2'd1, 5'h10);
        check("ill_clr",     io_out8, 8'h00);

        // Long strobe: one command only
        io_in7  = {5'h00, 2'd3};
        cmd_stb = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        repeat (10) tick();
        cmd_stb = 1'b0;
        tick();
        check("spare_ill",   io_out8, 8'h40);
        send_cmd(2'd1, 5'h10);
        check("spare_clr",   io_out8, 8'h00);
        send_cmd(2'd1, 5'h0B);
        check("cnt_once",    io_out8, exp_cnt);

        // Counter wraps after 256 further commands
        for (int i = 0; i < 256; i++) send_cmd(2'd1, 5'h0B);
        check("cnt_wrap",    io_out8, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
